// File: rtl/one_hot_seq_if.sv
// Control/status bundle of the one-hot sequencer.
// master drives en/dir/load/load_idx; slave returns state/idx/last/done/err.
interface one_hot_seq_if #(
  parameter int N_STATES = 4,
  parameter int IDX_W    = $clog2(N_STATES)
);
  logic                en;
  logic                dir;
  logic                load;
  logic [IDX_W-1:0]    load_idx;
  logic [N_STATES-1:0] state;
  logic [IDX_W-1:0]    idx;
  logic                last;
  logic                done;
  logic                err;

  modport master (
    output en, dir, load, load_idx,
    input  state, idx, last, done, err
  );

  modport slave (
    input  en, dir, load, load_idx,
    output state, idx, last, done, err
  );
endinterface

// File: rtl/one_hot_seq.sv
// Parametrised one-hot ring sequencer: fwd/back, wrap or one-shot, load, err.
// Ports: clk, rst (sync, active high), bus (one_hot_seq_if.slave).
module one_hot_seq #(
  parameter int N_STATES = 4,
  parameter int IDX_W    = $clog2(N_STATES),
  parameter bit ONE_SHOT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  one_hot_seq_if.slave bus
);

  localparam int NI = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LP_LAST =
    IDX_W'(N_STATES - 1);
  // Bit i set when load_idx == i is a real state.
  localparam logic [NI-1:0] LP_VLD =
    {NI{1'b1}} >> (NI - N_STATES);

  logic [N_STATES-1:0] r_state, w_nxt_state;
  logic [IDX_W-1:0]    r_idx, w_nxt_idx;
  logic                r_last, w_nxt_last;
  logic                r_done, w_nxt_done;
  logic                r_err, w_nxt_err;

  logic                w_onehot;
  logic                w_term;
  logic                w_step_term;
  logic                w_ld_ok;
  logic [IDX_W-1:0]    w_step;

  assign w_onehot = (r_state != '0) &&
    ((r_state & (r_state - 1'b1)) == '0);

  assign w_ld_ok = LP_VLD[bus.load_idx];

  always_comb begin
    w_step = '0;
    if (bus.dir) begin
      w_step = (r_idx == '0) ? LP_LAST : r_idx - 1'b1;
    end else begin
      w_step = (r_idx == LP_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Terminal depends on the direction applied this cycle.
  assign w_term = bus.dir ? (r_idx == '0)
                          : (r_idx == LP_LAST);
  assign w_step_term = bus.dir ? (w_step == '0)
                               : (w_step == LP_LAST);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_last  = 1'b0;
    w_nxt_done  = r_done;
    w_nxt_err   = r_err;
    if (!w_onehot) begin
      w_nxt_state = N_STATES'(1);
      w_nxt_idx   = '0;
      w_nxt_done  = 1'b0;
      w_nxt_err   = 1'b1;
    end else if (bus.load) begin
      if (w_ld_ok) begin
        w_nxt_state = N_STATES'(1) << bus.load_idx;
        w_nxt_idx   = bus.load_idx;
        w_nxt_done  = 1'b0;
      end
    end else if (bus.en && !r_done) begin
      if (ONE_SHOT && w_term) begin
        w_nxt_done = 1'b1;
      end else begin
        w_nxt_state = N_STATES'(1) << w_step;
        w_nxt_idx   = w_step;
        w_nxt_last  = w_step_term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= N_STATES'(1);
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_last  <= w_nxt_last;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
    end
  end

  assign bus.state = r_state;
  assign bus.idx   = r_idx;
  assign bus.last  = r_last;
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_one_hot_seq.sv
// Directed bench for one_hot_seq: N=4 wrap, N=4 one-shot, N=7 wrap.
// Checks reset, walk, reverse, one-shot halt, load, illegal state.
module tb_one_hot_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  one_hot_seq_if #(.N_STATES(4)) ifa ();
  one_hot_seq_if #(.N_STATES(4)) ifb ();
  one_hot_seq_if #(.N_STATES(7)) ifc ();

  one_hot_seq #(.N_STATES(4), .ONE_SHOT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  one_hot_seq #(.N_STATES(4), .ONE_SHOT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );
  one_hot_seq #(.N_STATES(7), .ONE_SHOT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ia;
    logic [2:0] ic;
    ifa.en = 0; ifa.dir = 0; ifa.load = 0; ifa.load_idx = '0;
    ifb.en = 0; ifb.dir = 0; ifb.load = 0; ifb.load_idx = '0;
    ifc.en = 0; ifc.dir = 0; ifc.load = 0; ifc.load_idx = '0;

    // reset
    tick(); tick();
    chk("rst_a_state", 32'(ifa.state), 32'h1);
    chk("rst_a_idx",   32'(ifa.idx),   32'h0);
    chk("rst_a_last",  32'(ifa.last),  32'h0);
    chk("rst_a_done",  32'(ifa.done),  32'h0);
    chk("rst_a_err",   32'(ifa.err),   32'h0);
    chk("rst_b_done",  32'(ifb.done),  32'h0);
    chk("rst_c_state", 32'(ifc.state), 32'h1);
    rst = 0;

    // forward walk, N=4 and N=7 together
    ifa.en = 1; ifc.en = 1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      ia = 4'(i % 4);
      ic = 3'(i % 7);
      chk($sformatf("fw4_idx%0d", i), 32'(ifa.idx), 32'(ia));
      chk($sformatf("fw4_st%0d", i), 32'(ifa.state),
          32'(1 << ia));
      chk($sformatf("fw4_last%0d", i), 32'(ifa.last),
          32'(ia == 3));
      chk($sformatf("fw7_idx%0d", i), 32'(ifc.idx), 32'(ic));
      chk($sformatf("fw7_last%0d", i), 32'(ifc.last),
          32'(ic == 6));
    end
    ifa.en = 0; ifc.en = 0;

    // hold
    tick();
    chk("hold_idx",  32'(ifa.idx),  32'h1);
    chk("hold_last", 32'(ifa.last), 32'h0);

    // reverse from idx 0
    ifa.load = 1; ifa.load_idx = 2'd0;
    tick();
    chk("ld0_idx", 32'(ifa.idx), 32'h0);
    ifa.load = 0; ifa.dir = 1; ifa.en = 1;
    tick();
    chk("bw_idx1",  32'(ifa.idx),   32'h3);
    chk("bw_st1",   32'(ifa.state), 32'h8);
    chk("bw_last1", 32'(ifa.last),  32'h0);
    tick();
    chk("bw_st2",   32'(ifa.state), 32'h4);
    chk("bw_last2", 32'(ifa.last),  32'h0);
    tick();
    chk("bw_st3",   32'(ifa.state), 32'h2);
    chk("bw_idx3",  32'(ifa.idx),   32'h1);
    tick();
    chk("bw_idx4",  32'(ifa.idx),   32'h0);
    chk("bw_last4", 32'(ifa.last),  32'h1);
    tick();
    chk("bw_idx5",  32'(ifa.idx),   32'h3);
    chk("bw_last5", 32'(ifa.last),  32'h0);
    chk("a_done0",  32'(ifa.done),  32'h0);
    ifa.en = 0; ifa.dir = 0;

    // one-shot
    ifb.en = 1;
    tick();
    chk("os_idx1", 32'(ifb.idx), 32'h1);
    tick();
    chk("os_idx2", 32'(ifb.idx), 32'h2);
    chk("os_done2", 32'(ifb.done), 32'h0);
    tick();
    chk("os_idx3",  32'(ifb.idx),  32'h3);
    chk("os_last3", 32'(ifb.last), 32'h1);
    chk("os_done3", 32'(ifb.done), 32'h0);
    tick();
    chk("os_idx4",  32'(ifb.idx),  32'h3);
    chk("os_last4", 32'(ifb.last), 32'h0);
    chk("os_done4", 32'(ifb.done), 32'h1);
    tick();
    tick();
    chk("os_idx6",  32'(ifb.idx),   32'h3);
    chk("os_st6",   32'(ifb.state), 32'h8);
    chk("os_last6", 32'(ifb.last),  32'h0);
    chk("os_done6", 32'(ifb.done),  32'h1);
    ifb.load = 1; ifb.load_idx = 2'd1;
    tick();
    chk("os_ld_idx",  32'(ifb.idx),  32'h1);
    chk("os_ld_done", 32'(ifb.done), 32'h0);
    ifb.load = 0;
    tick();
    chk("os_rearm_idx", 32'(ifb.idx), 32'h2);
    ifb.en = 0;

    // load priority over en
    ifa.load = 1; ifa.load_idx = 2'd0;
    tick();
    chk("ld_pre_idx", 32'(ifa.idx), 32'h0);
    ifa.en = 1; ifa.load_idx = 2'd2;
    tick();
    chk("ld_en_idx", 32'(ifa.idx),   32'h2);
    chk("ld_en_st",  32'(ifa.state), 32'h4);
    ifa.load_idx = 2'd3;
    tick();
    chk("ld_term_idx",  32'(ifa.idx),  32'h3);
    chk("ld_term_last", 32'(ifa.last), 32'h0);
    ifa.load = 0; ifa.en = 0;

    // out-of-range load ignored (N=7, idx 7)
    ifc.load = 1; ifc.en = 1; ifc.load_idx = 3'd7;
    tick();
    chk("ld_bad_idx", 32'(ifc.idx),   32'h2);
    chk("ld_bad_st",  32'(ifc.state), 32'h4);
    ifc.load_idx = 3'd6;
    tick();
    chk("ld6_st",   32'(ifc.state), 32'h40);
    chk("ld6_last", 32'(ifc.last),  32'h0);
    ifc.load = 0; ifc.en = 0;

    // illegal state
    force dut_a.r_state = 4'b0110;
    tick();
    chk("ill_err",  32'(ifa.err),  32'h1);
    chk("ill_idx",  32'(ifa.idx),  32'h0);
    chk("ill_last", 32'(ifa.last), 32'h0);
    release dut_a.r_state;
    tick();
    chk("ill_st",  32'(ifa.state), 32'h1);
    chk("ill_err2", 32'(ifa.err),  32'h1);
    ifa.en = 1;
    tick(); tick();
    chk("ill_run_idx", 32'(ifa.idx),   32'h2);
    chk("ill_run_st",  32'(ifa.state), 32'h4);
    chk("ill_sticky",  32'(ifa.err),   32'h1);

    // reset mid-sequence with en held
    rst = 1;
    tick();
    chk("mrst_st",   32'(ifa.state), 32'h1);
    chk("mrst_idx",  32'(ifa.idx),   32'h0);
    chk("mrst_last", 32'(ifa.last),  32'h0);
    chk("mrst_err",  32'(ifa.err),   32'h0);
    chk("mrst_c",    32'(ifc.idx),   32'h0);
    rst = 0; ifa.en = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
